// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - issue queue with CDB wakeup and a registered valid/ready issue stage
//
// Buffers renamed ops and tracks the readiness of both source operands by
// snooping one CDB tag per cycle. Each cycle at most one op whose operands
// are both ready moves into the registered issue stage.
//
// Optional build macro: RS_OLDEST_FIRST_EN
//   defined   - each entry keeps an allocation age stamp; select takes the oldest eligible entry
//   undefined - select takes the lowest-index eligible entry; no age storage
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   flush                      drop all entries and the issue stage
//   in_valid / in_ready        allocate handshake from rename
//   in_sr1_p, in_sr2_p, in_dr_p, in_s1_ready, in_s2_ready,
//   in_aluOp, in_FU, in_imm, in_ROB_num   renamed op fields
//   cdb_valid, cdb_tag         result broadcast snooped for wakeup
//   issue_valid / issue_ready  registered output handshake to execute
//   issue_sr1_p .. issue_ROB_num          fields of the issued op
//   occupancy                  number of valid entries
module reservation_station #(
  parameter int RS_DEPTH = 8,
  parameter int TAG_W    = 6,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_sr1_p,
  input  logic [TAG_W-1:0] in_sr2_p,
  input  logic [TAG_W-1:0] in_dr_p,
  input  logic             in_s1_ready,
  input  logic             in_s2_ready,
  input  logic [1:0]       in_aluOp,
  input  logic [1:0]       in_FU,
  input  logic [31:0]      in_imm,
  input  logic [15:0]      in_ROB_num,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [TAG_W-1:0] issue_sr1_p,
  output logic [TAG_W-1:0] issue_sr2_p,
  output logic [TAG_W-1:0] issue_dr_p,
  output logic [1:0]       issue_aluOp,
  output logic [1:0]       issue_FU,
  output logic [31:0]      issue_imm,
  output logic [15:0]      issue_ROB_num,
  output logic [CNT_W-1:0] occupancy
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  // Entry state
  logic [RS_DEPTH-1:0] ent_valid;
  logic [RS_DEPTH-1:0] ent_s1_rdy;
  logic [RS_DEPTH-1:0] ent_s2_rdy;
  logic [TAG_W-1:0]    ent_sr1 [RS_DEPTH];
  logic [TAG_W-1:0]    ent_sr2 [RS_DEPTH];
  logic [TAG_W-1:0]    ent_dr  [RS_DEPTH];
  logic [1:0]          ent_alu [RS_DEPTH];
  logic [1:0]          ent_fu  [RS_DEPTH];
  logic [31:0]         ent_imm [RS_DEPTH];
  logic [15:0]         ent_rob [RS_DEPTH];

  logic [CNT_W-1:0]    occ_q;
  logic [RS_DEPTH-1:0] elig;
  logic                any_elig;
  logic                accept;
  logic                load;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                s1_bypass;
  logic                s2_bypass;

  // Back-pressure comes only from the registered count, so a slot freed by
  // this cycle's select is not reusable until the next cycle.
  assign in_ready  = (occ_q != CNT_W'(RS_DEPTH));
  assign accept    = in_valid && in_ready;
  assign occupancy = occ_q;

  assign elig     = ent_valid & ent_s1_rdy & ent_s2_rdy;
  assign any_elig = |elig;
  assign load     = (!issue_valid || issue_ready) && any_elig;

  // A broadcast in the same cycle as allocation must not be missed.
  assign s1_bypass = cdb_valid && (cdb_tag == in_sr1_p);
  assign s2_bypass = cdb_valid && (cdb_tag == in_sr2_p);

  // Lowest-index free slot: scan downward so the last hit is the lowest.
  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) free_idx = i[IDX_W-1:0];
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  logic [CNT_W:0] ent_age [RS_DEPTH];
  logic [CNT_W:0] alloc_cnt;
  logic [CNT_W:0] sel_diff;
  logic           sel_found;

  // Oldest eligible entry: a stamp is older when (stamp - best) is negative
  // in CNT_W+1 bit two's complement, which tolerates counter wrap.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    sel_diff  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (elig[i]) begin
        sel_diff = ent_age[i] - ent_age[sel_idx];
        if (!sel_found || sel_diff[CNT_W]) begin
          sel_idx   = i[IDX_W-1:0];
          sel_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_cnt <= '0;
    end else if (accept && !flush) begin
      alloc_cnt <= alloc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) ent_age[free_idx] <= alloc_cnt;
  end
`else
  // Lowest-index eligible entry.
  always_comb begin
    sel_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) sel_idx = i[IDX_W-1:0];
    end
  end
`endif

  // Payload storage needs no reset: an entry is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_sr1[free_idx] <= in_sr1_p;
      ent_sr2[free_idx] <= in_sr2_p;
      ent_dr[free_idx]  <= in_dr_p;
      ent_alu[free_idx] <= in_aluOp;
      ent_fu[free_idx]  <= in_FU;
      ent_imm[free_idx] <= in_imm;
      ent_rob[free_idx] <= in_ROB_num;
    end
  end

  // Control state and issue stage. Flush outranks accept, select and wakeup.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid     <= '0;
      ent_s1_rdy    <= '0;
      ent_s2_rdy    <= '0;
      occ_q         <= '0;
      issue_valid   <= 1'b0;
      issue_sr1_p   <= '0;
      issue_sr2_p   <= '0;
      issue_dr_p    <= '0;
      issue_aluOp   <= '0;
      issue_FU      <= '0;
      issue_imm     <= '0;
      issue_ROB_num <= '0;
    end else if (flush) begin
      ent_valid   <= '0;
      occ_q       <= '0;
      issue_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (cdb_valid && ent_valid[i]) begin
          if (ent_sr1[i] == cdb_tag) ent_s1_rdy[i] <= 1'b1;
          if (ent_sr2[i] == cdb_tag) ent_s2_rdy[i] <= 1'b1;
        end
      end

      if (load) begin
        issue_valid        <= 1'b1;
        issue_sr1_p        <= ent_sr1[sel_idx];
        issue_sr2_p        <= ent_sr2[sel_idx];
        issue_dr_p         <= ent_dr[sel_idx];
        issue_aluOp        <= ent_alu[sel_idx];
        issue_FU           <= ent_fu[sel_idx];
        issue_imm          <= ent_imm[sel_idx];
        issue_ROB_num      <= ent_rob[sel_idx];
        ent_valid[sel_idx] <= 1'b0;
      end else if (issue_ready) begin
        issue_valid <= 1'b0;
      end

      // The free slot is invalid in registered state, so it never collides
      // with the selected slot or with a wakeup above.
      if (accept) begin
        ent_valid[free_idx]  <= 1'b1;
        ent_s1_rdy[free_idx] <= in_s1_ready | s1_bypass;
        ent_s2_rdy[free_idx] <= in_s2_ready | s2_bypass;
      end

      occ_q <= occ_q + CNT_W'(accept) - CNT_W'(load);
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - self-checking bench for reservation_station
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [5:0]  in_sr1_p, in_sr2_p, in_dr_p;
  logic        in_s1_ready, in_s2_ready;
  logic [1:0]  in_aluOp, in_FU;
  logic [31:0] in_imm;
  logic [15:0] in_ROB_num;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic        issue_valid, issue_ready;
  logic [5:0]  issue_sr1_p, issue_sr2_p, issue_dr_p;
  logic [1:0]  issue_aluOp, issue_FU;
  logic [31:0] issue_imm;
  logic [15:0] issue_ROB_num;
  logic [3:0]  occupancy;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  reservation_station #(.RS_DEPTH(8), .TAG_W(6), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1_p(in_sr1_p), .in_sr2_p(in_sr2_p), .in_dr_p(in_dr_p),
    .in_s1_ready(in_s1_ready), .in_s2_ready(in_s2_ready),
    .in_aluOp(in_aluOp), .in_FU(in_FU), .in_imm(in_imm), .in_ROB_num(in_ROB_num),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_sr1_p(issue_sr1_p), .issue_sr2_p(issue_sr2_p), .issue_dr_p(issue_dr_p),
    .issue_aluOp(issue_aluOp), .issue_FU(issue_FU), .issue_imm(issue_imm),
    .issue_ROB_num(issue_ROB_num), .occupancy(occupancy)
  );

  // Reference model: a pool of 8 slots, each op tagged with a global sequence number.
  typedef struct {
    bit          v, r1, r2;
    logic [5:0]  sr1, sr2, dr;
    logic [1:0]  alu, fu;
    logic [31:0] imm;
    logic [15:0] rob;
    int          seq;
  } ent_t;

  ent_t m [8];
  ent_t m_out;
  bit   m_iv;
  int   m_seq;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) if (m[i].v) c++;
    return c;
  endfunction

  // Applies one clock edge worth of rules to the model, using the inputs currently driven.
  function automatic void model_step();
    int  cnt, sel, fre;
    bit  load;
    if (reset) begin
      for (int i = 0; i < 8; i++) m[i].v = 0;
      m_iv  = 0;
      m_out = '{default: 0};
      return;
    end
    if (flush) begin
      for (int i = 0; i < 8; i++) m[i].v = 0;
      m_iv = 0;
      return;
    end
    cnt = 0; sel = -1; fre = -1;
    for (int i = 0; i < 8; i++) begin
      if (m[i].v) cnt++;
      else if (fre < 0) fre = i;
      if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RS_OLDEST_FIRST_EN
        if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    load = (!m_iv || issue_ready) && (sel >= 0);
    if (load) begin
      m_out = m[sel];
      m_iv = 1;
      m[sel].v = 0;
    end else if (issue_ready) begin
      m_iv = 0;
    end
    if (cdb_valid) begin
      for (int i = 0; i < 8; i++) begin
        if (m[i].v && m[i].sr1 == cdb_tag) m[i].r1 = 1;
        if (m[i].v && m[i].sr2 == cdb_tag) m[i].r2 = 1;
      end
    end
    if (in_valid && cnt != 8) begin
      m[fre].v   = 1;
      m[fre].sr1 = in_sr1_p; m[fre].sr2 = in_sr2_p; m[fre].dr = in_dr_p;
      m[fre].alu = in_aluOp; m[fre].fu = in_FU;
      m[fre].imm = in_imm;   m[fre].rob = in_ROB_num;
      m[fre].r1  = in_s1_ready || (cdb_valid && cdb_tag == in_sr1_p);
      m[fre].r2  = in_s2_ready || (cdb_valid && cdb_tag == in_sr2_p);
      m[fre].seq = m_seq;
      m_seq++;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_sr1_p = 0; in_sr2_p = 0; in_dr_p = 0;
    in_s1_ready = 0; in_s2_ready = 0; in_aluOp = 0; in_FU = 0;
    in_imm = 0; in_ROB_num = 0;
  endtask

  task automatic drive_op(input int sr1, input int sr2, input int dr,
                          input bit s1r, input bit s2r, input int rob);
    in_valid = 1;
    in_sr1_p = 6'(sr1); in_sr2_p = 6'(sr2); in_dr_p = 6'(dr);
    in_s1_ready = s1r; in_s2_ready = s2r;
    in_aluOp = 2'(rob); in_FU = 2'(rob >> 2);
    in_imm = 32'hA5A5_0000 | 32'(rob);
    in_ROB_num = 16'(rob);
  endtask

  task automatic do_reset();
    idle_in();
    flush = 0; cdb_valid = 0; cdb_tag = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    issue_ready = 0;
    do_reset();
    checks++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %0b want 0", issue_valid); else passes++;
    checks++; if (occupancy !== 4'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else passes++;
    checks++; if (issue_ROB_num !== 16'd0 || issue_dr_p !== 6'd0 || issue_imm !== 32'd0)
      $display("FAIL reset_issue_fields: got rob=%0d dr=%0d imm=%0h want 0", issue_ROB_num, issue_dr_p, issue_imm); else passes++;
  endtask

  task automatic test_basic();
    do_reset();
    issue_ready = 1;
    drive_op(3, 4, 9, 1, 1, 5);
    tick();
    idle_in();
    checks++; if (occupancy !== 4'd1 || issue_valid !== 1'b0)
      $display("FAIL t1_accept: got occ=%0d iv=%0b want occ=1 iv=0", occupancy, issue_valid); else passes++;
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_dr_p !== 6'd9 || issue_ROB_num !== 16'd5)
      $display("FAIL t1_issue: got iv=%0b dr=%0d rob=%0d want 1/9/5", issue_valid, issue_dr_p, issue_ROB_num); else passes++;
    checks++; if (occupancy !== 4'd0) $display("FAIL t1_occ: got %0d want 0", occupancy); else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (issue_valid !== 1'b0) $display("FAIL t1_empty_drop: got %0b want 0", issue_valid); else passes++;
    end
  endtask

  task automatic test_wakeup();
    do_reset();
    issue_ready = 1;
    drive_op(7, 8, 11, 0, 1, 6);
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (issue_valid !== 1'b0) $display("FAIL t2_early_issue: got %0b want 0", issue_valid); else passes++;
    end
    cdb_valid = 1; cdb_tag = 7;
    tick();
    cdb_valid = 0;
    checks++; if (issue_valid !== 1'b0) $display("FAIL t2_wake_edge: got %0b want 0", issue_valid); else passes++;
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_ROB_num !== 16'd6)
      $display("FAIL t2_issue: got iv=%0b rob=%0d want 1/6", issue_valid, issue_ROB_num); else passes++;
  endtask

  task automatic test_bypass();
    do_reset();
    issue_ready = 1;
    drive_op(12, 13, 14, 0, 1, 7);
    cdb_valid = 1; cdb_tag = 12;
    tick();
    idle_in();
    cdb_valid = 0;
    checks++; if (occupancy !== 4'd1) $display("FAIL t3_occ: got %0d want 1", occupancy); else passes++;
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_ROB_num !== 16'd7 || occupancy !== 4'd0)
      $display("FAIL t3_issue: got iv=%0b rob=%0d occ=%0d want 1/7/0", issue_valid, issue_ROB_num, occupancy); else passes++;
  endtask

  task automatic test_same_tag();
    do_reset();
    issue_ready = 1;
    drive_op(44, 44, 1, 0, 0, 77);
    tick();
    idle_in();
    cdb_valid = 1; cdb_tag = 44;
    tick();
    cdb_valid = 0;
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_ROB_num !== 16'd77)
      $display("FAIL same_tag_issue: got iv=%0b rob=%0d want 1/77", issue_valid, issue_ROB_num); else passes++;
  endtask

  task automatic test_full();
    do_reset();
    issue_ready = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (in_ready !== 1'b1) $display("FAIL t4_ready_before_full: got %0b want 1", in_ready); else passes++;
      drive_op(16 + i, 32 + i, i, 0, 0, 100 + i);
      tick();
    end
    checks++; if (in_ready !== 1'b0 || occupancy !== 4'd8)
      $display("FAIL t4_full: got rdy=%0b occ=%0d want 0/8", in_ready, occupancy); else passes++;
    drive_op(1, 2, 3, 1, 1, 200);
    tick();
    idle_in();
    checks++; if (occupancy !== 4'd8 || issue_valid !== 1'b0)
      $display("FAIL t4_ignored: got occ=%0d iv=%0b want 8/0", occupancy, issue_valid); else passes++;
    cdb_valid = 1; cdb_tag = 19;
    tick();
    cdb_tag = 35;
    tick();
    cdb_valid = 0;
    checks++; if (issue_valid !== 1'b0) $display("FAIL t4_wake_edge: got %0b want 0", issue_valid); else passes++;
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_ROB_num !== 16'd103 || occupancy !== 4'd7 || in_ready !== 1'b1)
      $display("FAIL t4_select: got iv=%0b rob=%0d occ=%0d rdy=%0b want 1/103/7/1",
               issue_valid, issue_ROB_num, occupancy, in_ready); else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_ROB_num !== 16'd103 || issue_dr_p !== 6'd3)
        $display("FAIL t4_hold: got iv=%0b rob=%0d dr=%0d want 1/103/3", issue_valid, issue_ROB_num, issue_dr_p); else passes++;
    end
    issue_ready = 1;
    tick();
    checks++; if (issue_valid !== 1'b0 || occupancy !== 4'd7)
      $display("FAIL t4_drain: got iv=%0b occ=%0d want 0/7", issue_valid, occupancy); else passes++;
  endtask

  task automatic test_order();
    int first, second;
`ifdef RS_OLDEST_FIRST_EN
    first = 1; second = 2;
`else
    first = 2; second = 1;
`endif
    do_reset();
    issue_ready = 1;
    drive_op(61, 61, 0, 0, 0, 10); tick();
    drive_op(60, 60, 0, 0, 0, 11); tick();
    drive_op(60, 60, 0, 0, 0, 12); tick();
    drive_op(30, 30, 0, 0, 0, 1);  tick();
    idle_in();
    cdb_valid = 1; cdb_tag = 61;
    tick();
    cdb_valid = 0;
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_ROB_num !== 16'd10)
      $display("FAIL t5_slot0_out: got iv=%0b rob=%0d want 1/10", issue_valid, issue_ROB_num); else passes++;
    drive_op(30, 30, 0, 0, 0, 2);
    tick();
    idle_in();
    cdb_valid = 1; cdb_tag = 30;
    tick();
    cdb_valid = 0;
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_ROB_num !== 16'(first))
      $display("FAIL t5_first: got iv=%0b rob=%0d want 1/%0d", issue_valid, issue_ROB_num, first); else passes++;
    tick();
    checks++; if (issue_valid !== 1'b1 || issue_ROB_num !== 16'(second))
      $display("FAIL t5_second: got iv=%0b rob=%0d want 1/%0d", issue_valid, issue_ROB_num, second); else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    issue_ready = 0;
    drive_op(1, 2, 3, 1, 1, 300);
    tick();
    for (int i = 1; i < 6; i++) begin
      drive_op(50 + i, 50 + i, i, 0, 0, 300 + i);
      tick();
    end
    idle_in();
    checks++; if (occupancy !== 4'd5 || issue_valid !== 1'b1 || issue_ROB_num !== 16'd300)
      $display("FAIL t6_setup: got occ=%0d iv=%0b rob=%0d want 5/1/300", occupancy, issue_valid, issue_ROB_num); else passes++;
    flush = 1;
    tick();
    flush = 0;
    checks++; if (occupancy !== 4'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL t6_flush: got occ=%0d iv=%0b rdy=%0b want 0/0/1", occupancy, issue_valid, in_ready); else passes++;
    issue_ready = 1;
    cdb_valid = 1; cdb_tag = 51;
    tick();
    cdb_valid = 0;
    tick();
    tick();
    checks++; if (issue_valid !== 1'b0 || occupancy !== 4'd0)
      $display("FAIL t6_no_ghost: got iv=%0b occ=%0d want 0/0", issue_valid, occupancy); else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 99) < 60);
      in_sr1_p    = 6'($urandom_range(0, 7));
      in_sr2_p    = 6'($urandom_range(0, 7));
      in_dr_p     = 6'($urandom);
      in_s1_ready = ($urandom_range(0, 1) == 1);
      in_s2_ready = ($urandom_range(0, 1) == 1);
      in_aluOp    = 2'($urandom);
      in_FU       = 2'($urandom);
      in_imm      = $urandom;
      in_ROB_num  = 16'(n);
      cdb_valid   = ($urandom_range(0, 99) < 40);
      cdb_tag     = 6'($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 99) < 70);
      flush       = ($urandom_range(0, 199) == 0);
      tick();
      checks++; if (in_ready !== (m_count() != 8))
        $display("FAIL rnd_in_ready cyc %0d: got %0b want %0b", n, in_ready, m_count() != 8); else passes++;
      checks++; if (occupancy !== 4'(m_count()))
        $display("FAIL rnd_occupancy cyc %0d: got %0d want %0d", n, occupancy, m_count()); else passes++;
      checks++; if (issue_valid !== m_iv)
        $display("FAIL rnd_issue_valid cyc %0d: got %0b want %0b", n, issue_valid, m_iv); else passes++;
      if (m_iv) begin
        checks++;
        if (issue_ROB_num !== m_out.rob || issue_sr1_p !== m_out.sr1 || issue_sr2_p !== m_out.sr2 ||
            issue_dr_p !== m_out.dr || issue_imm !== m_out.imm || issue_aluOp !== m_out.alu || issue_FU !== m_out.fu)
          $display("FAIL rnd_issue_fields cyc %0d: got rob=%0d dr=%0d imm=%0h want rob=%0d dr=%0d imm=%0h",
                   n, issue_ROB_num, issue_dr_p, issue_imm, m_out.rob, m_out.dr, m_out.imm);
        else passes++;
      end
    end
    flush = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_seq = 0;
    m_iv = 0;
    m_out = '{default: 0};
    for (int i = 0; i < 8; i++) m[i] = '{default: 0};
    reset = 1; flush = 0; cdb_valid = 0; cdb_tag = 0; issue_ready = 0;
    idle_in();
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_same_tag();
    test_full();
    test_order();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
